// File: rtl/compactor_pkg.sv
// compactor_pkg: widths, parity tap masks over {co,sum} and MISR polynomial for the compactor
package compactor_pkg;
  localparam int SIG_W = 6;
  localparam int SUM_W = 16;
  localparam logic [SIG_W-1:0][SUM_W:0] TAP_MASK = {
    17'h0D555, 17'h1AAAA, 17'h0E001, 17'h01E00, 17'h101F0, 17'h1000F
  };
  localparam logic [SIG_W-1:0] MISR_POLY = 6'h03;
endpackage

// File: rtl/compactor_xor_tree.sv
// compactor_xor_tree: one masked XOR-reduce per signature bit over {co,sum}
module compactor_xor_tree
  import compactor_pkg::*;
(
  input  logic [SUM_W:0]   bits,
  output logic [SIG_W-1:0] p
);
  genvar i;
  for (i = 0; i < SIG_W; i++) begin : g_tap
    assign p[i] = ^(bits & TAP_MASK[i]);
  end
endmodule

// File: rtl/compactor.sv
// compactor: registered 6-bit space compactor of {co,sum}; define COMPACTOR_MISR_EN for a x^6+x+1 MISR output register
module compactor
  import compactor_pkg::*;
#(
  parameter int N = SUM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     sum,
  input  logic             co,
  output logic [SIG_W-1:0] com_res
);
  logic [SIG_W-1:0] p;
  if (N != SUM_W) begin : g_bad_n
    $error("compactor: only N=16 is supported");
  end
  compactor_xor_tree u_tree (
    .bits ({co, sum}),
    .p    (p)
  );
  always_ff @(posedge clk)
`ifdef COMPACTOR_MISR_EN
    com_res <= rst ? '0 : {com_res[SIG_W-2:0], 1'b0} ^ (com_res[SIG_W-1] ? MISR_POLY : '0) ^ p;
`else
    com_res <= rst ? '0 : p;
`endif
endmodule

// File: tb/tb_compactor.sv
// tb_compactor: table-driven and scoreboarded checks of compactor in both COMPACTOR_MISR_EN builds
module tb_compactor;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] sum = '0;
  logic        co = 0;
  logic [5:0]  com_res;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [5:0]  model = '0;
  logic [5:0]  sb_q[$];
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic [5:0]  e;
    string       name;
  } vec_t;
  vec_t tbl[$];

  compactor dut (
    .clk     (clk),
    .rst     (rst),
    .sum     (sum),
    .co      (co),
    .com_res (com_res)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required end before 2000000", $time);
    $fatal(1);
  end

  function automatic logic [5:0] ref_p(input logic [15:0] s, input logic c);
    ref_p[0] = s[0] ^ s[1] ^ s[2] ^ s[3] ^ c;
    ref_p[1] = s[4] ^ s[5] ^ s[6] ^ s[7] ^ s[8] ^ c;
    ref_p[2] = s[9] ^ s[10] ^ s[11] ^ s[12];
    ref_p[3] = s[13] ^ s[14] ^ s[15] ^ s[0];
    ref_p[4] = s[1] ^ s[3] ^ s[5] ^ s[7] ^ s[9] ^ s[11] ^ s[13] ^ s[15] ^ c;
    ref_p[5] = s[0] ^ s[2] ^ s[4] ^ s[6] ^ s[8] ^ s[10] ^ s[12] ^ s[14] ^ s[15];
  endfunction

  function automatic logic [5:0] next_model(input logic [5:0] st, input logic r, input logic [15:0] s, input logic c);
`ifdef COMPACTOR_MISR_EN
    return r ? 6'h00 : ({st[4:0], 1'b0} ^ (st[5] ? 6'h03 : 6'h00) ^ ref_p(s, c));
`else
    return r ? 6'h00 : ref_p(s, c);
`endif
  endfunction

  task automatic step(input logic r, input logic [15:0] s, input logic c,
                      input logic use_e, input logic [5:0] e, input string name);
    logic [5:0] exp_v;
    rst = r;
    sum = s;
    co = c;
    model = next_model(model, r, s, c);
    sb_q.push_back(use_e ? e : model);
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    n_chk++;
    if (com_res === exp_v) n_pass++;
    else $display("FAIL %s: com_res=%h required %h (sum=%h co=%b rst=%b)", name, com_res, exp_v, s, c, r);
  endtask

  initial begin
    tbl.push_back('{16'hFFFF, 1'b0, 6'h22, "all_ones"});
    tbl.push_back('{16'h0000, 1'b1, 6'h13, "co_only"});
    tbl.push_back('{16'h0000, 1'b0, 6'h00, "all_zero"});
    tbl.push_back('{16'hFFFF, 1'b1, 6'h31, "all_ones_co"});
    tbl.push_back('{16'h0001, 1'b0, 6'h29, "walk0"});
    tbl.push_back('{16'h0002, 1'b0, 6'h11, "walk1"});
    tbl.push_back('{16'h0004, 1'b0, 6'h21, "walk2"});
    tbl.push_back('{16'h0008, 1'b0, 6'h11, "walk3"});
    tbl.push_back('{16'h0010, 1'b0, 6'h22, "walk4"});
    tbl.push_back('{16'h0020, 1'b0, 6'h12, "walk5"});
    tbl.push_back('{16'h0040, 1'b0, 6'h22, "walk6"});
    tbl.push_back('{16'h0080, 1'b0, 6'h12, "walk7"});
    tbl.push_back('{16'h0100, 1'b0, 6'h22, "walk8"});
    tbl.push_back('{16'h0200, 1'b0, 6'h14, "walk9"});
    tbl.push_back('{16'h0400, 1'b0, 6'h24, "walk10"});
    tbl.push_back('{16'h0800, 1'b0, 6'h14, "walk11"});
    tbl.push_back('{16'h1000, 1'b0, 6'h24, "walk12"});
    tbl.push_back('{16'h2000, 1'b0, 6'h18, "walk13"});
    tbl.push_back('{16'h4000, 1'b0, 6'h28, "walk14"});
    tbl.push_back('{16'h8000, 1'b0, 6'h38, "walk15"});

    step(1, 16'(($urandom)), 1'($urandom), 1, 6'h00, "reset_hold0");
    step(1, 16'(($urandom)), 1'($urandom), 1, 6'h00, "reset_hold1");
    step(0, 16'hFFFF, 0, 1, 6'h22, "first_after_reset");
    step(0, 16'h0000, 1, 0, 6'h00, "co_after_ones");

    // reset before each table vector so the MISR build also yields plain p
    foreach (tbl[k]) begin
      step(1, 16'h0000, 0, 1, 6'h00, "table_reset");
      step(0, tbl[k].s, tbl[k].c, 1, tbl[k].e, tbl[k].name);
      n_chk++;
      if (com_res != 6'h00 || k < 3) n_pass++;
      else $display("FAIL nonzero_%s: com_res=%h required nonzero", tbl[k].name, com_res);
    end

    for (int i = 0; i < 20; i++) step(0, 16'($urandom), 1'($urandom), 0, 6'h00, "stream_pre");
    step(1, 16'($urandom), 1'($urandom), 1, 6'h00, "mid_reset");
    begin
      logic [15:0] s;
      logic        c;
      s = 16'($urandom);
      c = 1'($urandom);
      step(0, s, c, 1, ref_p(s, c), "release_captures_p");
    end

    for (int i = 0; i < 1000; i++) step(0, 16'($urandom), 1'($urandom), 0, 6'h00, "random");

`ifdef COMPACTOR_MISR_EN
    step(1, 16'h0000, 0, 1, 6'h00, "misr_reset");
    step(0, 16'hFFFF, 0, 1, 6'h22, "misr_first");
    step(0, 16'hFFFF, 0, 1, 6'h25, "misr_second");
`else
    step(0, 16'hFFFF, 0, 1, 6'h22, "hold_ones0");
    step(0, 16'hFFFF, 0, 1, 6'h22, "hold_ones1");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/compactor.md
Name: compactor

Overview:
- Space compactor for DFT response compaction of the adder example.
- Folds the 16-bit adder sum plus carry-out (17 observation bits) into a 6-bit signature through fixed XOR parity trees.
- The signature is registered once per clock.
- Sits between the adder under test and the tester/scan-out observation point.

Parameters:
- N, 16, width of the sum input. Only 16 is supported; any other value shall fail elaboration via a generate-time check.

Ports:
- clk      input   1   rising-edge clock
- rst      input   1   synchronous reset, active-high
- sum      input   N   adder sum bits under observation
- co       input   1   adder carry-out under observation
- com_res  output  6   compacted signature (registered)

Behaviour:
- Combinational parity vector p[5:0], where "^" means XOR-reduce of the listed bits:
  - p[0] = sum[0]^sum[1]^sum[2]^sum[3]^co
  - p[1] = sum[4]^sum[5]^sum[6]^sum[7]^sum[8]^co
  - p[2] = sum[9]^sum[10]^sum[11]^sum[12]
  - p[3] = sum[13]^sum[14]^sum[15]^sum[0]
  - p[4] = sum[1]^sum[3]^sum[5]^sum[7]^sum[9]^sum[11]^sum[13]^sum[15]^co
  - p[5] = sum[0]^sum[2]^sum[4]^sum[6]^sum[8]^sum[10]^sum[12]^sum[14]^sum[15]
- Every input bit feeds at least one output bit, so any single-bit error is always visible.
- Registered output:
  - On a clk rising edge with rst=1: com_res <= 6'h00.
  - Otherwise com_res <= p.
  - Latency is exactly 1 cycle; com_res holds its value between edges.
- Reset:
  - Reset takes priority over data on the same edge.
  - Asserting reset mid-stream clears com_res on the next edge.
  - After rst deasserts, the first edge captures the current p.
- Key values: p = 6'h22 for sum=16'hFFFF, co=0; p = 6'h13 for sum=16'h0000, co=1; p = 6'h00 for all-zero inputs.
- No X-propagation masking: X inputs propagate to the affected output bits.

Optional Feature:
- Macro: COMPACTOR_MISR_EN.
- When defined, the output register becomes a 6-bit MISR with primitive polynomial x^6+x+1:
  - Next state = {com_res[4:0],1'b0} ^ (com_res[5] ? 6'h03 : 6'h00) ^ p.
  - Reset value is 6'h00.
  - The first cycle after reset yields exactly p.
- When not defined, plain 1-cycle registered space compaction as above.
- Port list is identical in both builds.

Decomposition:
- Package compactor_pkg holds:
  - SIG_W = 6 and SUM_W = 16 constants.
  - The six 17-bit tap masks over {co,sum} as localparams: 17'h1000F, 17'h101F0, 17'h01E00, 17'h0E001, 17'h1AAAA, 17'h0D555.
  - MISR_POLY = 6'h03.
- Sub-module compactor_xor_tree computes p from {co,sum} using the masks (one masked XOR-reduce per output bit).
- The top module holds only the register/MISR logic.

Test Plan:
- rst=1 for 2 cycles with arbitrary inputs -> com_res=6'h00; rst low, sum=16'hFFFF, co=0, one edge -> com_res=6'h22.
- sum=16'h0000, co=1 -> com_res=6'h13 one cycle later.
- Walking-one sweep over sum[0..15] and co with the other inputs 0 -> each result is nonzero and matches the masks (e.g. sum=16'h0001 -> 6'h29; sum=16'h8000 -> 6'h38; co only -> 6'h13).
- Assert rst in the middle of a random stream -> com_res=6'h00 on that edge; the next edge after release equals p of the current inputs.
- 1000 random vectors -> com_res matches the reference XOR model delayed by one cycle.
- COMPACTOR_MISR_EN build: after reset, sum=16'hFFFF, co=0 held for 2 edges -> com_res=6'h22 then 6'h25.
